// File: rtl/mem_reader_pkg.sv
`default_nettype none
// ==========================================================================
// mem_reader_pkg : shared state encoding and address helpers for the reader
// Revision: 1.0
// ==========================================================================
package mem_reader_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

  localparam int unsigned c_WORD_BYTES = 8;

  // Number of low address bits that select a byte inside one data word.
  function automatic int unsigned align_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ==========================================================================
// sync_fifo : single-clock FIFO with occupancy count, sync active-high reset
// Revision: 1.0
// ==========================================================================
module sync_fifo #(
  parameter  int unsigned Width   = 65,
  parameter  int unsigned Depth   = 2,
  localparam int unsigned c_CNT_W = $clog2(Depth + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [Width-1:0]   data_i,
  input  logic               pop_i,
  output logic [Width-1:0]   data_o,
  output logic [c_CNT_W-1:0] count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned c_PTR_W = $clog2(Depth);

  logic [Width-1:0]   mem_q [Depth];
  logic [c_PTR_W-1:0] wr_ptr_q;
  logic [c_PTR_W-1:0] rd_ptr_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic               w_do_push;
  logic               w_do_pop;

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
  assign w_do_pop  = pop_i && (cnt_q != '0);
  assign w_do_push = push_i && ((cnt_q != c_CNT_W'(Depth)) || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= (wr_ptr_q == c_PTR_W'(Depth - 1)) ? '0 : wr_ptr_q + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= (rd_ptr_q == c_PTR_W'(Depth - 1)) ? '0 : rd_ptr_q + c_PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   cnt_q <= cnt_q + c_CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - c_CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == c_CNT_W'(Depth));
  assign empty_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_word_reader.sv
`default_nettype none
// ==========================================================================
// mem_word_reader : burst reader for a 1-cycle-latency memory port -> stream
// Revision: 1.0
// ==========================================================================
module mem_word_reader
  import mem_reader_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 8 * c_WORD_BYTES,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [CntWidth-1:0]  cmd_len_i,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned          c_OFF_BITS   = align_bits(DataWidth);
  localparam logic [AddrWidth-1:0] c_INCR       = AddrWidth'(DataWidth / 8);
  localparam logic [AddrWidth-1:0] c_ALIGN_MASK =
      ~((AddrWidth'(1) << c_OFF_BITS) - AddrWidth'(1));
  localparam int unsigned          c_CNT_W      = $clog2(FifoDepth + 1);
  localparam int unsigned          c_OUT_W      = c_CNT_W + 1;

  rd_state_e            state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] addr_d;
  logic [CntWidth-1:0]  rem_q;
  logic [CntWidth-1:0]  rem_d;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 done_q;

  logic                 w_mem_req;
  logic                 w_pop;
  logic                 w_credit_ok;
  logic                 w_last_issue;
  logic [c_CNT_W-1:0]   w_fifo_cnt;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DataWidth:0]   w_fifo_rdata;
  logic [c_OUT_W-1:0]   w_outstanding;

  assign addr_d       = addr_q + c_INCR;
  assign rem_d        = rem_q - CntWidth'(1);
  assign w_last_issue = (rem_q == CntWidth'(1));
  assign w_pop        = ~rst_i & ~w_fifo_empty & out_ready_i;

  // Credit counts buffered plus in-flight words; a same-cycle pop frees a slot.
  assign w_outstanding = c_OUT_W'(w_fifo_cnt) + c_OUT_W'(inflight_q) - c_OUT_W'(w_pop);
  assign w_credit_ok   = ~(w_fifo_full & ~w_pop) & (w_outstanding < c_OUT_W'(FifoDepth));
  assign w_mem_req     = ~rst_i & (state_q == RD_ISSUE) & w_credit_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= RD_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= w_mem_req;
      inflight_last_q <= w_mem_req & w_last_issue;
      done_q          <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= cmd_addr_i & c_ALIGN_MASK;
              rem_q   <= cmd_len_i;
              state_q <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (w_mem_req) begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            if (w_last_issue) begin
              state_q <= RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (w_pop && w_fifo_rdata[DataWidth]) begin
            state_q <= RD_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .Width (DataWidth + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .data_i  ({inflight_last_q, mem_rdata_i}),
    .pop_i   (w_pop),
    .data_o  (w_fifo_rdata),
    .count_o (w_fifo_cnt),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Every output is forced low while reset is asserted, independent of stale state.
  assign cmd_ready_o = ~rst_i & (state_q == RD_IDLE);
  assign mem_req_o   = w_mem_req;
  assign mem_addr_o  = rst_i ? '0 : addr_q;
  assign out_valid_o = ~rst_i & ~w_fifo_empty;
  assign out_data_o  = rst_i ? '0 : w_fifo_rdata[DataWidth-1:0];
  assign out_last_o  = ~rst_i & ~w_fifo_empty & w_fifo_rdata[DataWidth];
  assign busy_o      = ~rst_i & (state_q != RD_IDLE);
  assign done_o      = ~rst_i & done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_word_reader.sv
`default_nettype none
// ==========================================================================
// tb_mem_word_reader : self-checking bench with a transaction-level model
// Revision: 1.0
// ==========================================================================
module tb_mem_word_reader;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [CW-1:0] cmd_len_i = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  mem_word_reader #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .CntWidth  (CW),
    .FifoDepth (FD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Debug ROM image: 20 words at address 0, zeros up to word 63, hash elsewhere.
  logic [63:0] rom [20];
  initial begin
    for (int i = 0; i < 20; i++) begin
      rom[i] = {32'hDB60_0000 + 32'(i) * 32'h11, 32'h0010_0073 ^ (32'(i) << 7)};
    end
  end

  function automatic logic [63:0] model_word(input logic [63:0] a);
    logic [63:0] idx;
    idx = a >> 3;
    if (idx < 20) return rom[idx];
    if (idx < 64) return 64'd0;
    return {a[31:0] ^ 32'hA5A5_1234, ~a[31:0] + 32'h0F0F_0F0F};
  endfunction

  // Memory slave: data appears the cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    mem_rdata_i <= mem_req_o ? model_word(mem_addr_o) : {$urandom, $urandom};
  end

  int ready_mode = 0;
  int pat_cnt    = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready_i = ((pat_cnt % 4) == 3);
        2:       out_ready_i = ($urandom_range(0, 9) < 7);
        default: out_ready_i = 1'b1;
      endcase
      pat_cnt++;
    end
  end

  // Reference model state and per-test logs
  longint      cyc = 0;
  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_word_q[$];
  bit          m_busy = 0;
  bit          m_done_next = 0;
  int          m_len = 0;
  int          m_issued = 0;
  int          m_popped = 0;
  bit          prev_hold = 0;
  logic [64:0] prev_out = '0;
  longint      acc_log[$];
  longint      req_log[$];
  longint      pop_log[$];
  longint      last_log[$];
  longint      done_log[$];
  logic [63:0] addr_log[$];
  logic [63:0] data_log[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      chk("rst_ctrl", {58'd0, cmd_ready_o, mem_req_o, out_valid_o, out_last_o, busy_o, done_o}, 64'd0);
      chk("rst_addr", mem_addr_o, 64'd0);
      chk("rst_data", out_data_o, 64'd0);
      exp_addr_q.delete();
      exp_word_q.delete();
      m_busy = 0; m_done_next = 0; prev_hold = 0; m_issued = 0; m_popped = 0;
    end else begin
      chk("cmd_ready", cmd_ready_o, !m_busy);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done_next);
      if (done_o) done_log.push_back(cyc);
      m_done_next = 0;
      if (!m_busy && cmd_valid_i) begin
        acc_log.push_back(cyc);
        m_len = int'(cmd_len_i);
        m_issued = 0;
        m_popped = 0;
        if (m_len == 0) begin
          m_done_next = 1;
        end else begin
          m_busy = 1;
          for (int k = 0; k < m_len; k++) begin
            logic [63:0] a;
            a = (cmd_addr_i & ~64'h7) + 64'(k) * 64'd8;
            exp_addr_q.push_back(a);
            exp_word_q.push_back(model_word(a));
          end
        end
      end
      if (mem_req_o) begin
        chk("req_pending", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) chk("mem_addr", mem_addr_o, exp_addr_q.pop_front());
        req_log.push_back(cyc);
        addr_log.push_back(mem_addr_o);
        m_issued++;
      end
      if (prev_hold) begin
        chk("hold_valid", out_valid_o, 1);
        chk("hold_data", {out_last_o, out_data_o}, prev_out);
      end
      if (out_valid_o) chk("valid_when_busy", m_busy, 1);
      if (out_valid_o && out_ready_i) begin
        chk("word_pending", exp_word_q.size() > 0, 1);
        if (exp_word_q.size() > 0) begin
          chk("out_data", out_data_o, exp_word_q[0]);
          chk("out_last", out_last_o, exp_word_q.size() == 1);
          void'(exp_word_q.pop_front());
          m_popped++;
          if (exp_word_q.size() == 0) begin
            chk("req_count", m_issued, m_len);
            m_busy = 0;
            m_done_next = 1;
          end
        end
        pop_log.push_back(cyc);
        data_log.push_back(out_data_o);
        if (out_last_o) last_log.push_back(cyc);
      end
      chk("outstanding", (m_issued - m_popped) <= FD, 1);
      prev_hold = out_valid_o && !out_ready_i;
      prev_out  = {out_last_o, out_data_o};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_log.delete(); req_log.delete(); pop_log.delete(); last_log.delete();
    done_log.delete(); addr_log.delete(); data_log.delete();
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [15:0] l);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_len_i   = l;
    while (!cmd_ready_o && n < 3000) begin
      tick();
      n++;
    end
    chk("cmd_accept_timeout", n < 3000, 1);
    tick();
    cmd_valid_i = 1'b0;
    cmd_addr_i  = {$urandom, $urandom};
    cmd_len_i   = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || m_done_next) && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
  endtask

  initial begin
    longint a0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Basic burst with literal cycle and address expectations
    ready_mode = 0;
    clear_logs();
    send_cmd(64'h800, 16'd4);
    wait_idle();
    a0 = acc_log[0];
    chk("basic_req_n", req_log.size(), 4);
    chk("basic_pop_n", pop_log.size(), 4);
    if (req_log.size() == 4 && pop_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("basic_req_cyc", req_log[i], a0 + 1 + i);
        chk("basic_addr", addr_log[i], 64'h800 + 64'(i) * 8);
        chk("basic_pop_cyc", pop_log[i], a0 + 3 + i);
      end
    end
    chk("basic_last_n", last_log.size(), 1);
    if (last_log.size() == 1) chk("basic_last_cyc", last_log[0], a0 + 6);
    chk("basic_done_n", done_log.size(), 1);
    if (done_log.size() == 1) chk("basic_done_cyc", done_log[0], a0 + 7);

    // Zero-length command
    clear_logs();
    send_cmd(64'h1230, 16'd0);
    wait_idle();
    chk("len0_reqs", req_log.size(), 0);
    chk("len0_done_n", done_log.size(), 1);
    if (done_log.size() == 1) chk("len0_done_cyc", done_log[0], acc_log[0] + 1);

    // Unaligned start
    clear_logs();
    send_cmd(64'h803, 16'd1);
    wait_idle();
    chk("unaligned_n", addr_log.size(), 1);
    if (addr_log.size() == 1) chk("unaligned_addr", addr_log[0], 64'h800);

    // Address wrap
    clear_logs();
    send_cmd(64'hFFFF_FFFF_FFFF_FFF8, 16'd2);
    wait_idle();
    chk("wrap_n", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("wrap_addr0", addr_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_addr1", addr_log[1], 64'h0);
    end

    // Backpressure 0,0,0,1
    ready_mode = 1;
    clear_logs();
    send_cmd(64'h3000, 16'd8);
    wait_idle();
    chk("bp_reqs", req_log.size(), 8);
    chk("bp_pops", pop_log.size(), 8);

    // Reset during cycle 3 of a 6-word burst
    ready_mode = 0;
    clear_logs();
    send_cmd(64'h1000, 16'd6);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (6) tick();
    chk("rst_no_pops", pop_log.size(), 0);
    clear_logs();
    send_cmd(64'h1100, 16'd3);
    wait_idle();
    chk("post_rst_pops", pop_log.size(), 3);

    // Debug ROM end-to-end, with a second command held while busy
    ready_mode = 2;
    clear_logs();
    send_cmd(64'h0, 16'd24);
    send_cmd(64'h40, 16'd1);
    wait_idle();
    chk("rom_pops", pop_log.size(), 25);
    if (pop_log.size() == 25) begin
      chk("rom_w0", data_log[0], 64'hDB60_0000_0010_0073);
      chk("rom_w1", data_log[1], 64'hDB60_0011_0010_00F3);
      for (int i = 20; i < 24; i++) chk("rom_zero", data_log[i], 64'd0);
      chk("rom_second", data_log[24], rom[8]);
    end
    chk("busy_cmd_n", acc_log.size(), 2);
    if (acc_log.size() == 2 && done_log.size() >= 1) chk("busy_cmd_cyc", acc_log[1], done_log[0]);

    // Randomized commands
    for (int t = 0; t < 25; t++) begin
      ready_mode = 2;
      send_cmd({$urandom, $urandom}, 16'($urandom_range(0, 12)));
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_word_reader.md
# mem_word_reader

Command-driven read initiator for the codebase's single-cycle-latency memory port, the same req/addr/rdata port that the debug ROM responds on. It accepts a start address and a word count, issues word-aligned reads, and buffers the returned words in a small FIFO. The words leave on a valid/ready stream with a last marker. The block sits between a control/DMA front end and any ROM-style slave that returns read data one cycle after `req`, has no grant, and never stalls.

## Interface
- `AddrWidth`, 64, byte address width of the memory port.
- `DataWidth`, 64, word width. The address increment is `DataWidth/8`.
- `CntWidth`, 16, width of the word-count field.
- `FifoDepth`, 2, output buffer depth. Must be ≥2. A depth of 2 sustains one word per cycle.
- `clk_i  in  1  clock`. Single clock domain.
- `rst_i  in  1  reset`. Synchronous, active-high.
- `cmd_valid_i  in  1  command valid`
- `cmd_ready_o  out  1  command accepted when both cmd_valid_i and cmd_ready_o are high`
- `cmd_addr_i  in  AddrWidth  start byte address. Low log2(DataWidth/8) bits are ignored (forced 0).`
- `cmd_len_i  in  CntWidth  number of words to read. 0 is legal.`
- `mem_req_o  out  1  read request`
- `mem_addr_o  out  AddrWidth  read byte address, word-aligned`
- `mem_rdata_i  in  DataWidth  read data, valid the cycle after mem_req_o`
- `out_valid_o  out  1  stream valid`
- `out_ready_i  in  1  stream ready`
- `out_data_o  out  DataWidth  stream data`
- `out_last_o  out  1  marks the final word of a command`
- `busy_o  out  1  high whenever the block is not in IDLE`
- `done_o  out  1  one-cycle pulse when a command completes`

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `cmd_ready_o`=1.
  - On accept with len>0: latch the aligned address into `addr_q`, set `rem_q`=len, go to ISSUE.
  - On accept with len=0: stay in IDLE, no `mem_req_o`, pulse `done_o` next cycle.
- **ISSUE**
  - Assert `mem_req_o` when credit is available. Credit rule: `fifo_cnt + inflight_q - pop < FifoDepth`, where `pop` = `out_valid_o & out_ready_i` in the same cycle.
  - On each issue: `addr_q += DataWidth/8` (wraps modulo 2^AddrWidth), `rem_q -= 1`.
  - The issue that brings `rem_q` to 0 moves the FSM to DRAIN.
- **Read return**
  - `inflight_q` is a register equal to the previous cycle's `mem_req_o`.
  - When `inflight_q`=1, push `mem_rdata_i` into the FIFO, tagged last if it is the final word of the command.
  - The credit rule guarantees the FIFO never overflows.
- **DRAIN**: when the word tagged last is popped, return to IDLE and pulse `done_o` in the following cycle. `cmd_ready_o` is also 1 in that cycle.
- **Commands while busy**: `cmd_ready_o`=0 outside IDLE; there is no command queuing.
- **Stream rules**: once `out_valid_o` is asserted, `out_data_o` and `out_last_o` hold stable until the handshake completes.
- **Reset**: synchronous reset at any point, including mid-burst, returns the block to IDLE and empties the FIFO.
  - Read data returning in the cycle after reset is discarded.
  - Reset values: `cmd_ready_o`=0 during reset and 1 after; all other outputs are 0.

## Timing
- Cycle 0: command accepted.
- Cycle 1: first `mem_req_o`.
- Cycle 2: the FIFO captures `mem_rdata_i` at the end of this cycle.
- Cycle 3: first `out_valid_o`.
- With `out_ready_i` held at 1, throughput is one word per cycle. Reads for an N-word command occupy cycles 1..N, and stream output occupies cycles 3..N+2.
- `done_o` pulses at cycle N+3.
- Backpressure: at most `FifoDepth` words are outstanding (buffered plus in flight). `mem_req_o` stalls with `mem_addr_o` held until credit returns.
- `mem_req_o` and `mem_addr_o` are combinational from registered state, with no dependence on `mem_rdata_i`.

## Structure
- Shared package `mem_reader_pkg`:
  - FSM state enum `rd_state_e`.
  - Word byte-size constant.
  - Alignment helper function.
- Natural sub-module: `sync_fifo`, parameterised on width (DataWidth+1 for data plus last) and depth. It provides count, push, pop, full and empty, and uses the same synchronous active-high reset.

## Test plan
- **Basic burst**: `addr` 0x800, `len` 4, `out_ready_i`=1, against a responder model that returns `mem[addr>>3]`.
  - `mem_addr_o` is 0x800, 0x808, 0x810, 0x818 in cycles 1–4.
  - Outputs appear in cycles 3–6 in order; `out_last_o` is set on cycle 6 only; `done_o` pulses in cycle 7.
- **Backpressure**: `len` 8 with `out_ready_i` toggled in a 0,0,0,1 pattern.
  - `fifo_cnt + inflight` never exceeds 2.
  - All 8 words arrive in order with no duplicates.
  - Exactly 8 `mem_req_o` pulses are issued.
- **Edge commands**:
  - `len` 0: no `mem_req_o`, `done_o` pulses one cycle after accept.
  - `addr` 0x803, `len` 1: `mem_addr_o`=0x800.
- **Address wrap**: `addr` 0xFFFF_FFFF_FFFF_FFF8, `len` 2 → `mem_addr_o` is 0xFFFF_FFFF_FFFF_FFF8, then 0x0.
- **Reset mid-burst**: assert `rst_i` for 1 cycle during cycle 3 of a 6-word burst.
  - All outputs are 0 during reset and no further `out_valid_o` follows.
  - A new command issued afterwards returns correct data.
- **End-to-end against the debug ROM**: read 24 words from address 0.
  - Words 0–19 match the ROM image.
  - Words 20–23 read 0.
  - A `cmd_valid_i` presented while busy is not accepted until after `done_o`.
